// File: rtl/psum_id_generator.sv
// psum_id_generator: fills per-row and per-column partial-sum IDs, one PE row per cycle.
module psum_id_generator #(
  parameter int NUM_ROWS = 3,
  parameter int NUM_COLS = 3,
  parameter int PSUM_ROW_ID_BITWIDTH = 4,
  parameter int PSUM_COL_ID_BITWIDTH = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_start,
  input  logic [3:0] i_layer_RS,
  output logic [0:NUM_ROWS*PSUM_ROW_ID_BITWIDTH-1] o_psum_row_id,
  output logic [0:NUM_ROWS*NUM_COLS*PSUM_COL_ID_BITWIDTH-1] o_psum_col_id,
  output logic o_busy,
  output logic o_done,
  output logic o_cfg_error
);
  localparam int RW = PSUM_ROW_ID_BITWIDTH;
  localparam int CW = PSUM_COL_ID_BITWIDTH;
  localparam int W = $clog2(NUM_ROWS + 16) + 1;
  typedef enum logic [1:0] {IDLE, GEN, DONE} state_t;
  state_t state;
  logic [W-1:0] row, base;
  logic [3:0] rs, pos;
  logic bad, active, last, wrap;
  // base is the first row of the current group; the group is active only if it fits entirely
  always_comb begin
    bad = i_layer_RS == 4'd0 || W'(i_layer_RS) > W'(NUM_ROWS);
    active = base + W'(rs) <= W'(NUM_ROWS);
    last = row == W'(NUM_ROWS - 1);
    wrap = pos == rs;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      row <= '0;
      base <= '0;
      rs <= '0;
      pos <= '0;
      o_psum_row_id <= '0;
      o_psum_col_id <= '0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
      o_cfg_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            rs <= i_layer_RS;
            row <= '0;
            base <= '0;
            pos <= 4'd1;
            o_psum_row_id <= '0;
            o_psum_col_id <= '0;
            o_cfg_error <= bad;
            o_busy <= 1'b1;
            o_done <= bad;
            state <= bad ? DONE : GEN;
          end
        end
        GEN: begin
          o_psum_row_id[row*RW +: RW] <= active ? RW'(pos) : '0;
          for (int c = 0; c < NUM_COLS; c++)
            o_psum_col_id[(row*NUM_COLS + c)*CW +: CW] <= active ? CW'(c + 1) : '0;
          pos <= wrap ? 4'd1 : pos + 4'd1;
          base <= wrap ? base + W'(rs) : base;
          row <= last ? row : row + 1'b1;
          o_done <= last;
          state <= last ? DONE : GEN;
        end
        default: begin
          o_done <= 1'b0;
          o_busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_psum_id_generator.sv
// tb_psum_id_generator: randomized passes checked against a modulo-arithmetic reference model.
module tb_psum_id_generator;
  localparam int NR = 3, NC = 3, RW = 4, CW = 4;
  logic clk = 0, rst = 1, start = 0;
  logic [3:0] rs_in = 0;
  logic [0:NR*RW-1] row_id;
  logic [0:NR*NC*CW-1] col_id;
  logic busy, done, cfg_error;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  psum_id_generator #(.NUM_ROWS(NR), .NUM_COLS(NC), .PSUM_ROW_ID_BITWIDTH(RW), .PSUM_COL_ID_BITWIDTH(CW)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_layer_RS(rs_in),
    .o_psum_row_id(row_id), .o_psum_col_id(col_id),
    .o_busy(busy), .o_done(done), .o_cfg_error(cfg_error)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic bit is_active(int rs, int r);
    return rs >= 1 && rs <= NR && r < (NR / rs) * rs;
  endfunction
  function automatic logic [63:0] exp_rows(int rs, int w);
    logic [63:0] v = 0;
    for (int r = 0; r < NR; r++)
      v = (v << RW) | 64'((r < w && is_active(rs, r)) ? (r % rs) + 1 : 0);
    return v;
  endfunction
  function automatic logic [63:0] exp_cols(int rs, int w);
    logic [63:0] v = 0;
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++)
        v = (v << CW) | 64'((r < w && is_active(rs, r)) ? (c + 1) % (1 << CW) : 0);
    return v;
  endfunction
  task automatic check_all(input string tag, input int rs, input int w, input bit b, input bit d, input bit e);
    chk({tag, ".row"}, 64'(row_id), exp_rows(rs, w));
    chk({tag, ".col"}, 64'(col_id), exp_cols(rs, w));
    chk({tag, ".busy"}, 64'(busy), 64'(b));
    chk({tag, ".done"}, 64'(done), 64'(d));
    chk({tag, ".err"}, 64'(cfg_error), 64'(e));
  endtask
  task automatic run_pass(input int rs, input bit noise);
    bit bad = rs == 0 || rs > NR;
    start = 1;
    rs_in = 4'(rs);
    tick;
    start = noise ? 1'($urandom) : 1'b0;
    if (noise) rs_in = 4'($urandom);
    if (bad) begin
      check_all("bad", rs, 0, 1, 1, 1);
      tick;
      start = 0;
      check_all("bad_idle", rs, 0, 0, 0, 1);
    end else begin
      check_all("acc", rs, 0, 1, 0, 0);
      for (int k = 1; k <= NR; k++) begin
        if (noise) begin
          start = 1'($urandom);
          rs_in = 4'($urandom);
        end
        tick;
        check_all("gen", rs, k, 1, k == NR, 0);
      end
      tick;
      start = 0;
      check_all("end", rs, NR, 0, 0, 0);
    end
  endtask
  initial begin
    start = 1;
    rs_in = 3;
    tick;
    tick;
    check_all("reset", 0, 0, 0, 0, 0);
    rst = 0;
    start = 0;
    tick;
    check_all("post_reset", 0, 0, 0, 0, 0);
    run_pass(3, 0);
    run_pass(1, 0);
    run_pass(2, 0);
    run_pass(0, 0);
    run_pass(3, 0);
    run_pass(5, 0);
    run_pass(1, 0);
    start = 1;
    rs_in = 3;
    tick;
    rs_in = 1;
    check_all("hold_acc", 3, 0, 1, 0, 0);
    for (int k = 1; k <= NR; k++) begin
      tick;
      check_all("hold_gen", 3, k, 1, k == NR, 0);
    end
    tick;
    check_all("hold_idle", 3, NR, 0, 0, 0);
    tick;
    start = 0;
    check_all("hold_reacc", 1, 0, 1, 0, 0);
    for (int k = 1; k <= NR; k++) begin
      tick;
      check_all("hold_gen2", 1, k, 1, k == NR, 0);
    end
    tick;
    check_all("hold_end", 1, NR, 0, 0, 0);
    start = 1;
    rs_in = 3;
    tick;
    start = 0;
    tick;
    check_all("abort_row0", 3, 1, 1, 0, 0);
    rst = 1;
    tick;
    rst = 0;
    check_all("abort", 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick;
      check_all("abort_quiet", 0, 0, 0, 0, 0);
    end
    for (int p = 0; p < 40; p++) begin
      int rs = $urandom_range(0, 7);
      run_pass(rs, 1);
      for (int g = $urandom_range(0, 3); g > 0; g--) begin
        tick;
        check_all("idle", rs, NR, 0, 0, rs == 0 || rs > NR);
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
